// File: rtl/gpio_input_responder_if.sv
// MEM-stage data bus as seen by a memory-mapped peripheral.
// Latency: none, this is only a signal bundle.
// Backpressure: none, the bus has no wait states.
interface gpio_input_responder_if;
  logic [31:0] address;
  logic [31:0] D_in;
  logic [3:0]  read_write;
  logic        rd_en;
  logic        hit;
  logic [31:0] D_out;

  modport master (
    output address, D_in, read_write, rd_en,
    input  hit, D_out
  );

  modport slave (
    input  address, D_in, read_write, rd_en,
    output hit, D_out
  );
endinterface

// File: rtl/gpio_input_responder.sv
// Switch/button input peripheral: sync, debounce, sticky W1C edge flags, level irq.
// Latency: loads are combinational; stores land on the edge ending the store cycle.
// Backpressure: none, every access completes in the cycle it is issued.
module gpio_input_responder #(
  parameter int          NUM_SW          = 16,
  parameter int          NUM_BTN         = 5,
  parameter int          DEBOUNCE_CYCLES = 100000,
  parameter logic [31:0] BASE_ADDR       = 32'h0000_1000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_SW-1:0]      sw_in,
  input  logic [NUM_BTN-1:0]     btn_in,
  gpio_input_responder_if.slave  bus,
  output logic                   irq
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic [CW-1:0]      tick_cnt;
  logic               tick;
  logic [NUM_SW-1:0]  sw_s1, sw_s2, sw_h0, sw_h1, sw_deb, sw_deb_next;
  logic [NUM_BTN-1:0] btn_s1, btn_s2, btn_h0, btn_h1, btn_deb, btn_deb_next;
  logic [NUM_BTN-1:0] btn_edge, btn_edge_next, irq_en, irq_en_next;
  logic [NUM_BTN-1:0] edge_clr, btn_rise;
  logic [31:0]        lane_mask, wr_bits;
  logic [1:0]         reg_sel;
  logic               store;
  logic               unused_bits;

  // Tick fires in the cycle whose edge wraps the counter back to 0.
  assign tick = (tick_cnt == CW'(DEBOUNCE_CYCLES - 1));

  // Free-running debounce sample timer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)    tick_cnt <= '0;
    else if (tick) tick_cnt <= '0;
    else           tick_cnt <= tick_cnt + CW'(1);
  end

  // Two-flop synchronizers for the raw board inputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sw_s1  <= '0;
      sw_s2  <= '0;
      btn_s1 <= '0;
      btn_s2 <= '0;
    end else begin
      sw_s1  <= sw_in;
      sw_s2  <= sw_s1;
      btn_s1 <= btn_in;
      btn_s2 <= btn_s1;
    end
  end

  // The 3-sample window is the two stored samples plus the one being taken
  // this tick, so a unanimous window updates the state on that same tick.
  always_comb begin
    sw_deb_next  = sw_deb;
    btn_deb_next = btn_deb;
    if (tick) begin
      sw_deb_next  = (sw_h1 & sw_h0 & sw_s2) | (sw_deb & (sw_h1 | sw_h0 | sw_s2));
      btn_deb_next = (btn_h1 & btn_h0 & btn_s2) | (btn_deb & (btn_h1 | btn_h0 | btn_s2));
    end
  end

  // Sample history shift and debounced state registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sw_h0   <= '0;
      sw_h1   <= '0;
      btn_h0  <= '0;
      btn_h1  <= '0;
      sw_deb  <= '0;
      btn_deb <= '0;
    end else begin
      if (tick) begin
        sw_h0  <= sw_s2;
        sw_h1  <= sw_h0;
        btn_h0 <= btn_s2;
        btn_h1 <= btn_h0;
      end
      sw_deb  <= sw_deb_next;
      btn_deb <= btn_deb_next;
    end
  end

  assign bus.hit   = (bus.address[31:4] == BASE_ADDR[31:4]);
  assign reg_sel   = bus.address[3:2];
  assign store     = bus.hit && (bus.read_write != 4'b0000);
  assign lane_mask = {{8{bus.read_write[3]}}, {8{bus.read_write[2]}},
                      {8{bus.read_write[1]}}, {8{bus.read_write[0]}}};
  assign wr_bits   = bus.D_in & lane_mask;
  // Byte offset and register bits beyond the implemented width are ignored.
  assign unused_bits = ^{bus.address[1:0], lane_mask, wr_bits};

  // Store decode, edge capture (a new rise beats a same-cycle W1C) and enables.
  always_comb begin
    irq_en_next = irq_en;
    edge_clr    = '0;
    if (store && reg_sel == 2'd3)
      irq_en_next = (irq_en & ~lane_mask[NUM_BTN-1:0]) | wr_bits[NUM_BTN-1:0];
    if (store && reg_sel == 2'd2)
      edge_clr = wr_bits[NUM_BTN-1:0];
    btn_rise      = btn_deb_next & ~btn_deb;
    btn_edge_next = (btn_edge & ~edge_clr) | btn_rise;
  end

  // Edge flags, interrupt enables and the registered interrupt request.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      btn_edge <= '0;
      irq_en   <= '0;
      irq      <= 1'b0;
    end else begin
      btn_edge <= btn_edge_next;
      irq_en   <= irq_en_next;
      irq      <= |(btn_edge_next & irq_en_next);
    end
  end

  // Load data mux; reads have no side effects and show pre-store values.
  always_comb begin
    bus.D_out = 32'h0;
    if (bus.hit && bus.rd_en) begin
      case (reg_sel)
        2'd0:    bus.D_out = 32'(sw_deb);
        2'd1:    bus.D_out = 32'(btn_deb);
        2'd2:    bus.D_out = 32'(btn_edge);
        default: bus.D_out = 32'(irq_en);
      endcase
    end
  end

endmodule
